// File: rtl/proj_pkg.sv
// Shared types and constants for the projectile slot arbiter.
// Direction codes and the per-slot lifecycle state.
package proj_pkg;

  localparam int DIR_W = 2;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd1;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd2;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_LAUNCH = 2'd1,
    SLOT_ACTIVE = 2'd2
  } slot_state_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/projectile_slot_fsm.sv
// One projectile slot: FREE -> LAUNCH -> ACTIVE -> FREE.
// Holds the owner and direction captured at allocation.
module projectile_slot_fsm
  import proj_pkg::*;
#(
  parameter int REQ_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc,
  input  logic [REQ_W-1:0] alloc_owner,
  input  logic [DIR_W-1:0] alloc_dir,
  input  logic             hit,
  output slot_state_t      state,
  output logic             launch,
  output logic             active,
  output logic             rel_pulse,
  output logic [REQ_W-1:0] owner,
  output logic [DIR_W-1:0] dir
);

  slot_state_t      state_q, state_d;
  logic [REQ_W-1:0] owner_q, owner_d;
  logic [DIR_W-1:0] dir_q, dir_d;

  // Next state; hits only count once the slot is ACTIVE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    unique case (state_q)
      SLOT_FREE: begin
        if (alloc) begin
          state_d = SLOT_LAUNCH;
          owner_d = alloc_owner;
          dir_d   = alloc_dir;
        end
      end
      SLOT_LAUNCH: state_d = SLOT_ACTIVE;
      SLOT_ACTIVE: begin
        if (hit) state_d = SLOT_FREE;
      end
      default: state_d = SLOT_FREE;
    endcase
  end

  // Slot state and latched shot attributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_FREE;
      owner_q <= '0;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
    end
  end

  assign state     = state_q;
  assign launch    = (state_q == SLOT_LAUNCH);
  assign active    = (state_q == SLOT_ACTIVE);
  assign rel_pulse = (state_q == SLOT_ACTIVE) && hit;
  assign owner     = owner_q;
  assign dir       = dir_q;

endmodule

// File: rtl/projectile_slot_arbiter.sv
// Round-robin fire arbiter over a pool of projectile slots,
// with per-requester cooldown and live-shot limits.
module projectile_slot_arbiter
  import proj_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int NUM_SLOTS   = 4,
  parameter  int COOLDOWN    = 30,
  parameter  int MAX_PER_REQ = 1,
  localparam int REQ_W  = clog2_min1(NUM_REQ),
  localparam int SLOT_W = clog2_min1(NUM_SLOTS),
  localparam int LC_W   = $clog2(MAX_PER_REQ + 1),
  localparam int FC_W   = $clog2(NUM_SLOTS + 1)
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       frame_tick,
  input  logic [NUM_REQ-1:0]         fire_req,
  input  logic [NUM_REQ*DIR_W-1:0]   req_dir,
  input  logic [NUM_SLOTS-1:0]       slot_collision,
  input  logic [NUM_SLOTS-1:0]       slot_offscreen,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_SLOTS-1:0]       slot_launch,
  output logic [NUM_SLOTS-1:0]       slot_active,
  output logic [NUM_SLOTS*REQ_W-1:0] slot_owner,
  output logic [NUM_SLOTS*DIR_W-1:0] slot_dir,
  output logic [FC_W-1:0]            free_count
);

  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [REQ_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         cd_q [NUM_REQ];
  logic [7:0]         cd_d [NUM_REQ];
  logic [LC_W-1:0]    live_q [NUM_REQ];
  logic [LC_W-1:0]    live_d [NUM_REQ];

  logic [NUM_REQ-1:0] elig;
  logic               win_vld;
  logic [REQ_W-1:0]   win_idx;
  logic [DIR_W-1:0]   win_dir;
  logic               tgt_vld;
  logic [SLOT_W-1:0]  tgt_idx;
  logic               do_grant;

  logic [NUM_SLOTS-1:0] alloc;
  logic [NUM_SLOTS-1:0] slot_hit;
  logic [NUM_SLOTS-1:0] slot_free;
  logic [NUM_SLOTS-1:0] rel;
  slot_state_t          st_w  [NUM_SLOTS];
  logic [REQ_W-1:0]     own_w [NUM_SLOTS];
  logic [DIR_W-1:0]     dir_w [NUM_SLOTS];

  // A requester may fire when cooled down and under its shot limit.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = fire_req[i]
             && (cd_q[i] == 8'd0)
             && (live_q[i] < LC_W'(MAX_PER_REQ));
    end
  end

  // First eligible requester at or after the pointer.
  always_comb begin
    int r;
    r       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      r = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_vld && elig[r]) begin
        win_vld = 1'b1;
        win_idx = REQ_W'(r);
      end
    end
  end

  // Lowest-index free slot is the allocation target.
  always_comb begin
    tgt_vld = 1'b0;
    tgt_idx = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (!tgt_vld && slot_free[s]) begin
        tgt_vld = 1'b1;
        tgt_idx = SLOT_W'(s);
      end
    end
  end

  assign do_grant = win_vld && tgt_vld;
  assign win_dir  = req_dir[int'(win_idx)*DIR_W +: DIR_W];

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    assign alloc[s]    = do_grant && (tgt_idx == SLOT_W'(s));
    assign slot_hit[s] = slot_collision[s] | slot_offscreen[s];

    projectile_slot_fsm #(
      .REQ_W (REQ_W)
    ) u_slot (
      .clk         (Clk),
      .rst_n       (Reset_n),
      .alloc       (alloc[s]),
      .alloc_owner (win_idx),
      .alloc_dir   (win_dir),
      .hit         (slot_hit[s]),
      .state       (st_w[s]),
      .launch      (slot_launch[s]),
      .active      (slot_active[s]),
      .rel_pulse   (rel[s]),
      .owner       (own_w[s]),
      .dir         (dir_w[s])
    );

    assign slot_free[s] = (st_w[s] == SLOT_FREE);
    assign slot_owner[s*REQ_W +: REQ_W] = own_w[s];
    assign slot_dir[s*DIR_W +: DIR_W]   = dir_w[s];
  end

  // Grant pulse and pointer advance past the winner.
  always_comb begin
    grant_d = '0;
    ptr_d   = ptr_q;
    if (do_grant) begin
      grant_d[win_idx] = 1'b1;
      if (int'(win_idx) == NUM_REQ - 1) ptr_d = '0;
      else ptr_d = win_idx + 1'b1;
    end
  end

  // Cooldown reload beats tick; live count nets grant and releases.
  always_comb begin
    int inc;
    int dec;
    inc = 0;
    dec = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc = (do_grant && (win_idx == REQ_W'(i))) ? 1 : 0;
      dec = 0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (rel[s] && (own_w[s] == REQ_W'(i))) dec = dec + 1;
      end
      live_d[i] = live_q[i] + LC_W'(inc) - LC_W'(dec);
      cd_d[i]   = cd_q[i];
      if (inc != 0) cd_d[i] = 8'(COOLDOWN);
      else if (frame_tick && (cd_q[i] != 8'd0))
        cd_d[i] = cd_q[i] - 8'd1;
    end
  end

  // Arbiter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      grant_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cd_q[i]   <= '0;
        live_q[i] <= '0;
      end
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        cd_q[i]   <= cd_d[i];
        live_q[i] <= live_d[i];
      end
    end
  end

  // Count of slots available for allocation.
  always_comb begin
    free_count = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      free_count = free_count + FC_W'(slot_free[s]);
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_projectile_slot_arbiter.sv
// Bench for projectile_slot_arbiter: vector table, corner
// sequences and random traffic against a slot-age model.
module tb_projectile_slot_arbiter;
  import proj_pkg::*;

  localparam int NR  = 4;
  localparam int NS  = 4;
  localparam int CDV = 30;
  localparam int MX  = 1;
  localparam logic [7:0] DIRS =
    {DIR_LEFT, DIR_DOWN, DIR_UP, DIR_RIGHT};

  logic          Clk;
  logic          Reset_n;
  logic          frame_tick;
  logic [NR-1:0] fire_req;
  logic [7:0]    req_dir;
  logic [NS-1:0] slot_collision;
  logic [NS-1:0] slot_offscreen;
  logic [NR-1:0] grant;
  logic [NS-1:0] slot_launch;
  logic [NS-1:0] slot_active;
  logic [7:0]    slot_owner;
  logic [7:0]    slot_dir;
  logic [2:0]    free_count;

  projectile_slot_arbiter #(
    .NUM_REQ     (NR),
    .NUM_SLOTS   (NS),
    .COOLDOWN    (CDV),
    .MAX_PER_REQ (MX)
  ) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_tick     (frame_tick),
    .fire_req       (fire_req),
    .req_dir        (req_dir),
    .slot_collision (slot_collision),
    .slot_offscreen (slot_offscreen),
    .grant          (grant),
    .slot_launch    (slot_launch),
    .slot_active    (slot_active),
    .slot_owner     (slot_owner),
    .slot_dir       (slot_dir),
    .free_count     (free_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks;
  int n_errors;

  // Model: slot age 0 = free, 1 = launching, 2 = flying.
  int m_age [NS];
  int m_own [NS];
  int m_dir [NS];
  int m_cd  [NR];
  int m_ptr;
  logic [NR-1:0] e_grant;

  typedef struct {
    logic       rst;
    logic [3:0] fire;
    logic       tick;
    logic [3:0] coll;
    logic [3:0] off;
    logic [3:0] eg;
    logic [3:0] el;
    logic [3:0] ea;
    logic [2:0] efc;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int m_live(input int r);
    int c;
    c = 0;
    for (int s = 0; s < NS; s++)
      if (m_age[s] > 0 && m_own[s] == r) c++;
    return c;
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < NS; s++) begin
      m_age[s] = 0;
      m_own[s] = 0;
      m_dir[s] = 0;
    end
    for (int r = 0; r < NR; r++) m_cd[r] = 0;
    m_ptr   = 0;
    e_grant = '0;
  endfunction

  function automatic void m_step(input logic [NR-1:0] f,
                                 input logic [7:0] d,
                                 input logic t,
                                 input logic [NS-1:0] h);
    int win;
    int tgt;
    win = -1;
    tgt = -1;
    for (int k = 0; k < NR; k++) begin
      int r;
      r = (m_ptr + k) % NR;
      if (win < 0 && f[r] && m_cd[r] == 0 && m_live(r) < MX)
        win = r;
    end
    for (int s = 0; s < NS; s++)
      if (tgt < 0 && m_age[s] == 0) tgt = s;
    if (tgt < 0) win = -1;
    for (int s = 0; s < NS; s++) begin
      if (m_age[s] >= 2 && h[s]) m_age[s] = 0;
      else if (m_age[s] > 0) m_age[s] = 2;
    end
    for (int r = 0; r < NR; r++) begin
      if (r == win) m_cd[r] = CDV;
      else if (t && m_cd[r] > 0) m_cd[r] = m_cd[r] - 1;
    end
    e_grant = '0;
    if (win >= 0) begin
      e_grant[win] = 1'b1;
      m_age[tgt] = 1;
      m_own[tgt] = win;
      m_dir[tgt] = int'(d[win*2 +: 2]);
      m_ptr = (win + 1) % NR;
    end
  endfunction

  task automatic check_all();
    logic [NS-1:0] el;
    logic [NS-1:0] ea;
    int fc;
    fc = 0;
    for (int s = 0; s < NS; s++) begin
      el[s] = (m_age[s] == 1);
      ea[s] = (m_age[s] >= 2);
      if (m_age[s] == 0) fc++;
    end
    chk("grant", 32'(grant), 32'(e_grant));
    chk("slot_launch", 32'(slot_launch), 32'(el));
    chk("slot_active", 32'(slot_active), 32'(ea));
    chk("free_count", 32'(free_count), fc);
    for (int s = 0; s < NS; s++) begin
      if (m_age[s] > 0) begin
        chk($sformatf("slot_owner[%0d]", s),
            32'(slot_owner[s*2 +: 2]), m_own[s]);
        chk($sformatf("slot_dir[%0d]", s),
            32'(slot_dir[s*2 +: 2]), m_dir[s]);
      end
    end
  endtask

  task automatic step(input logic [NR-1:0] f, input logic [7:0] d,
                      input logic t, input logic [NS-1:0] c,
                      input logic [NS-1:0] o);
    fire_req       = f;
    req_dir        = d;
    frame_tick     = t;
    slot_collision = c;
    slot_offscreen = o;
    m_step(f, d, t, c | o);
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    fire_req       = '0;
    frame_tick     = 1'b0;
    slot_collision = '0;
    slot_offscreen = '0;
    Reset_n        = 1'b0;
    #2;
    m_reset();
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  int ng;

  initial begin
    n_checks = 0;
    n_errors = 0;
    req_dir  = DIRS;
    m_reset();

    // Reset state
    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_launch", 32'(slot_launch), 0);
    chk("rst_active", 32'(slot_active), 0);
    chk("rst_owner", 32'(slot_owner), 0);
    chk("rst_dir", 32'(slot_dir), 0);
    chk("rst_free_count", 32'(free_count), NS);

    // Vector table: single shot, fill-up order, launch-time hit
    tbl[0]  = '{1'b1, 4'b0001, 1'b0, 4'h0, 4'h0,
                4'b0001, 4'b0001, 4'b0000, 3'd3};
    tbl[1]  = '{1'b0, 4'b0000, 1'b0, 4'h0, 4'h0,
                4'b0000, 4'b0000, 4'b0001, 3'd3};
    tbl[2]  = '{1'b1, 4'b1111, 1'b0, 4'h0, 4'h0,
                4'b0001, 4'b0001, 4'b0000, 3'd3};
    tbl[3]  = '{1'b0, 4'b1111, 1'b0, 4'h0, 4'h0,
                4'b0010, 4'b0010, 4'b0001, 3'd2};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 4'h0, 4'h0,
                4'b0100, 4'b0100, 4'b0011, 3'd1};
    tbl[5]  = '{1'b0, 4'b1111, 1'b0, 4'h0, 4'h0,
                4'b1000, 4'b1000, 4'b0111, 3'd0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'h0, 4'h0,
                4'b0000, 4'b0000, 4'b1111, 3'd0};
    tbl[7]  = '{1'b1, 4'b0001, 1'b0, 4'h0, 4'h0,
                4'b0001, 4'b0001, 4'b0000, 3'd3};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 4'h1, 4'h1,
                4'b0000, 4'b0000, 4'b0001, 3'd3};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 4'h0, 4'h0,
                4'b0000, 4'b0000, 4'b0001, 3'd3};
    tbl[10] = '{1'b0, 4'b0000, 1'b0, 4'h0, 4'h1,
                4'b0000, 4'b0000, 4'b0000, 3'd4};

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].fire, DIRS, tbl[i].tick,
           tbl[i].coll, tbl[i].off);
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].eg));
      chk($sformatf("tbl%0d_launch", i),
          32'(slot_launch), 32'(tbl[i].el));
      chk($sformatf("tbl%0d_active", i),
          32'(slot_active), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d_free", i),
          32'(free_count), 32'(tbl[i].efc));
      if (tbl[i].el[0] || tbl[i].ea[0])
        chk($sformatf("tbl%0d_dir0", i),
            32'(slot_dir[1:0]), 32'(DIR_RIGHT));
    end

    // Reset asserted while two shots are in flight
    do_reset();
    step(4'b0011, DIRS, 1'b0, 4'h0, 4'h0);
    step(4'b0011, DIRS, 1'b0, 4'h0, 4'h0);
    step(4'b0000, DIRS, 1'b0, 4'h0, 4'h0);
    chk("mid_pre_active", 32'(slot_active), 32'h3);
    Reset_n = 1'b0;
    #1;
    chk("mid_grant", 32'(grant), 0);
    chk("mid_launch", 32'(slot_launch), 0);
    chk("mid_active", 32'(slot_active), 0);
    chk("mid_owner", 32'(slot_owner), 0);
    chk("mid_dir", 32'(slot_dir), 0);
    chk("mid_free_count", 32'(free_count), NS);
    do_reset();

    // Held requester 0: live limit, then cooldown
    step(4'b0001, DIRS, 1'b0, 4'h0, 4'h0);
    chk("hold_first_grant", 32'(grant), 32'h1);
    ng = 0;
    for (int i = 0; i < 31; i++) begin
      step(4'b0001, DIRS, 1'b1, 4'h0, 4'h0);
      if (grant != 0) ng++;
    end
    chk("hold_live_block", ng, 0);
    step(4'b0001, DIRS, 1'b0, 4'h1, 4'h0);
    chk("hold_rel_cycle", 32'(grant), 0);
    step(4'b0001, DIRS, 1'b0, 4'h0, 4'h0);
    chk("hold_regrant", 32'(grant), 32'h1);
    step(4'b0001, DIRS, 1'b0, 4'h0, 4'h0);
    step(4'b0001, DIRS, 1'b0, 4'h1, 4'h0);
    ng = 0;
    for (int i = 0; i < 30; i++) begin
      step(4'b0001, DIRS, 1'b1, 4'h0, 4'h0);
      if (grant != 0) ng++;
    end
    chk("hold_cooldown_block", ng, 0);
    step(4'b0001, DIRS, 1'b0, 4'h0, 4'h0);
    chk("hold_cooldown_done", 32'(grant), 32'h1);

    // Release and pending request in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++)
      step(4'b1111, DIRS, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 30; i++)
      step(4'b0000, DIRS, 1'b1, 4'h0, 4'h0);
    step(4'b0100, DIRS, 1'b0, 4'b0100, 4'h0);
    chk("same_cyc_grant", 32'(grant), 0);
    chk("same_cyc_free", 32'(free_count), 1);
    step(4'b0100, DIRS, 1'b0, 4'h0, 4'h0);
    chk("next_cyc_grant", 32'(grant), 32'b0100);
    chk("next_cyc_launch", 32'(slot_launch), 32'b0100);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] f;
      logic [3:0] c;
      logic [3:0] o;
      if ($urandom_range(0, 699) == 0) do_reset();
      f = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) f = 4'hF;
      for (int b = 0; b < 4; b++) begin
        c[b] = ($urandom_range(0, 5) == 0);
        o[b] = ($urandom_range(0, 7) == 0);
      end
      step(f, 8'($urandom), 1'($urandom_range(0, 1)), c, o);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
